console_text_display: RTL and testbench
=======================================

Name: console_text_display

Overview:
- Display end of the console character interface. Accepts single-cycle character writes into an 80x30 text buffer (2400 bytes, address = row*80 + col).
- Scans the buffer out in 640x480 VGA raster order. Presents each character code plus glyph row/column, pixel-aligned with hsync/vsync, to a downstream font ROM / pixel mux.
- Includes a post-reset clear sequencer that fills the buffer with a blank character.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- CLEAR_CHAR, 8'h20, value written to every cell by the clear sequencer

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pixel_en  input  1  pixel-rate enable; raster and output pipeline advance only when 1
- console_addr  input  12  write address, 0..2399
- console_write  input  1  write strobe, sampled every clock cycle
- console_data  input  8  character to write
- clear_busy  output  1  high while the clear sequencer owns the write port
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_active  output  1  high for visible pixels
- char_code  output  8  character at the current pixel; 0 when not active
- glyph_row  output  4  pixel row within the 8x16 cell (v mod 16)
- glyph_col  output  3  pixel column within the cell (h mod 8)

Behaviour:
- Reset, all asynchronous:
  - h_count = 0 and v_count = 0.
  - hsync = 1, vsync = 1, video_active = 0, char_code = 0, glyph_row = 0, glyph_col = 0.
  - clear_busy = 1 and clear pointer = 0.
  - Buffer contents are not reset.
- Clear sequencer, states CLEAR and RUN:
  - In CLEAR, on every clock cycle (independent of pixel_en), write CLEAR_CHAR at the clear pointer, then increment the pointer.
  - After writing address 2399, go to RUN and drop clear_busy on the next cycle. Clearing takes 2400 cycles from reset release.
  - Console writes during CLEAR are dropped.
  - Reset asserted mid-clear restarts the clear from 0.
- Console writes, RUN state only:
  - When console_write = 1 and console_addr <= 2399, buf[console_addr] <= console_data at that clock edge.
  - Addresses >= 2400 are ignored and do not alias.
  - A write every cycle is supported; console_write held at 1 continuously is legal.
- Raster, advancing only when pixel_en = 1:
  - h_count runs 0..799 and wraps to 0.
  - When h_count wraps, v_count increments, running 0..524 and wrapping to 0.
  - Visible region: h < 640 and v < 480.
  - hsync low for h in 656..751; vsync low for v in 490..491.
- Read address:
  - col = h[9:3], row = v[8:4], addr = (row<<6) + (row<<4) + col.
  - The address is computed only in the visible region; otherwise it is don't-care.
- Pipeline: fixed latency of 2 pixel_en ticks from counter value to outputs.
  - Stage 1: the buffer is read synchronously at addr. Visible flag, hsync, vsync, glyph_row and glyph_col are registered.
  - Stage 2: all outputs are registered together. char_code = buffer data if visible, else 0.
  - When pixel_en = 0, every pipeline register holds its value.
- Read/write collision: a write and a raster read of the same address in the same cycle return the OLD data (read-before-write). The new data is seen on the next frame.

Test Plan:
- Reset release, pixel_en = 0 throughout → clear_busy high for exactly 2400 cycles, then low. Backdoor check: all cells = 0x20.
- After clear, write 0x41 to addr 0 and 0x5A to addr 2399; run one frame with pixel_en = 1 → char_code = 0x41 for output pixels (h 0..7, v 0..15) and 0x5A for (h 632..639, v 464..479). Output is 2 ticks after the corresponding counter values; glyph_col counts 0..7.
- Free-running pixel_en = 1 → hsync period 800 ticks with a 96-tick low pulse; vsync period 420000 ticks with a 1600-tick low pulse; video_active high for 640 of every 800 ticks on lines 0..479.
- pixel_en toggling 1/0 every cycle → same output sequence as free-running, stretched 2x; outputs stay stable on cycles with pixel_en = 0.
- Write addr 2400 and addr 4095 with 0x55 → no cell changes; cells 0 and 2399 keep their previous values.
- Write during CLEAR, then assert reset at clear pointer = 1000 → the dropped write has no effect; after reset release clear_busy is high for a full 2400 cycles.

Source files
------------

// File: rtl/console_text_display.sv
// console_text_display: 80x30 character buffer with a post-reset clear sequencer,
// scanned out in VGA raster order with a two-stage, pixel_en-qualified output pipeline.
`default_nettype none

module console_text_display #(
    parameter int        H_VISIBLE  = 640,
    parameter int        H_FRONT    = 16,
    parameter int        H_SYNC     = 96,
    parameter int        H_BACK     = 48,
    parameter int        V_VISIBLE  = 480,
    parameter int        V_FRONT    = 10,
    parameter int        V_SYNC     = 2,
    parameter int        V_BACK     = 33,
    parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [11:0] console_addr,
    input  logic        console_write,
    input  logic [7:0]  console_data,
    output logic        clear_busy,
    output logic        hsync,
    output logic        vsync,
    output logic        video_active,
    output logic [7:0]  char_code,
    output logic [3:0]  glyph_row,
    output logic [2:0]  glyph_col
);

    localparam int         c_cells     = 2400;
    localparam logic [11:0] c_last_addr = 12'(c_cells - 1);
    localparam logic [9:0] c_h_last    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_v_last    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] c_h_vis     = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis     = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_hs_end    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_vs_start  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_vs_end    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_clr_ptr;
    logic        w_we;
    logic [11:0] w_waddr;
    logic [7:0]  w_wdata;

    logic [7:0]  r_mem [0:c_cells-1];
    logic [7:0]  r_rd_data;

    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic        w_vis;
    logic        w_hs;
    logic        w_vs;
    logic [4:0]  w_row;
    logic [6:0]  w_col;
    logic [11:0] w_raddr;

    logic        r_s1_vis;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic [3:0]  r_s1_grow;
    logic [2:0]  r_s1_gcol;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 12'd1;
            end
        end
    end

    // The clear sequencer owns the single write port until the last cell is written.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = console_addr;
        w_wdata     = console_data;
        clear_busy  = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                clear_busy = 1'b1;
                w_we       = 1'b1;
                w_waddr    = r_clr_ptr;
                w_wdata    = CLEAR_CHAR;
                if (r_clr_ptr == c_last_addr) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_we = console_write && (console_addr <= c_last_addr);
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (pixel_en) begin
            if (r_h == c_h_last) begin
                r_h <= 10'd0;
                r_v <= (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    assign w_vis   = (r_h < c_h_vis) && (r_v < c_v_vis);
    assign w_hs    = !((r_h >= c_hs_start) && (r_h < c_hs_end));
    assign w_vs    = !((r_v >= c_vs_start) && (r_v < c_vs_end));
    assign w_row   = r_v[8:4];
    assign w_col   = r_h[9:3];
    // row*80 + col; held at 0 outside the visible area so the read never leaves the array.
    assign w_raddr = w_vis ? (({7'd0, w_row} << 6) + ({7'd0, w_row} << 4) + {5'd0, w_col})
                           : 12'd0;

    // Read and write in one block: a same-address collision returns the old data.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (pixel_en) begin
            r_rd_data <= r_mem[w_raddr];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_vis     <= 1'b0;
            r_s1_hs      <= 1'b1;
            r_s1_vs      <= 1'b1;
            r_s1_grow    <= 4'd0;
            r_s1_gcol    <= 3'd0;
            video_active <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            char_code    <= 8'd0;
            glyph_row    <= 4'd0;
            glyph_col    <= 3'd0;
        end else if (pixel_en) begin
            r_s1_vis     <= w_vis;
            r_s1_hs      <= w_hs;
            r_s1_vs      <= w_vs;
            r_s1_grow    <= r_v[3:0];
            r_s1_gcol    <= r_h[2:0];
            video_active <= r_s1_vis;
            hsync        <= r_s1_hs;
            vsync        <= r_s1_vs;
            char_code    <= r_s1_vis ? r_rd_data : 8'd0;
            glyph_row    <= r_s1_grow;
            glyph_col    <= r_s1_gcol;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_console_text_display.sv
// tb_console_text_display: randomized writes and raster scan-out checked against an
// arithmetic model of the display; a second, small-geometry instance exercises frame wrap.
`default_nettype none

module tb_console_text_display;

    localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVV = 32, SVF = 2, SVS = 2, SVB = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        pixel_en;
    logic [11:0] console_addr;
    logic        console_write;
    logic [7:0]  console_data;

    logic        w_busy_b, w_hs_b, w_vs_b, w_act_b;
    logic [7:0]  w_ch_b;
    logic [3:0]  w_gr_b;
    logic [2:0]  w_gc_b;
    logic        w_busy_s, w_hs_s, w_vs_s, w_act_s;
    logic [7:0]  w_ch_s;
    logic [3:0]  w_gr_s;
    logic [2:0]  w_gc_s;

    int n_vec = 0;
    int n_err = 0;
    int g_k   = 0;

    logic [7:0] model_mem [0:2399];

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [7:0] ch;
        logic [3:0] gr;
        logic [2:0] gc;
    } exp_t;

    console_text_display u_dut (
        .clock(clock), .reset(reset), .pixel_en(pixel_en),
        .console_addr(console_addr), .console_write(console_write), .console_data(console_data),
        .clear_busy(w_busy_b), .hsync(w_hs_b), .vsync(w_vs_b), .video_active(w_act_b),
        .char_code(w_ch_b), .glyph_row(w_gr_b), .glyph_col(w_gc_b)
    );

    console_text_display #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_small (
        .clock(clock), .reset(reset), .pixel_en(pixel_en),
        .console_addr(console_addr), .console_write(console_write), .console_data(console_data),
        .clear_busy(w_busy_s), .hsync(w_hs_s), .vsync(w_vs_s), .video_active(w_act_s),
        .char_code(w_ch_s), .glyph_row(w_gr_s), .glyph_col(w_gc_s)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s tick=%0d observed=%0h expected=%0h", tag, g_k, obs, exp);
        end
    endtask

    // Expected outputs after k pixel ticks since reset: pixel k-2 of the raster.
    function automatic exp_t model(input int k, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb);
        exp_t e;
        int p, ht, vt, h, v;
        e.hs = 1'b1; e.vs = 1'b1; e.act = 1'b0; e.ch = 8'h00; e.gr = 4'd0; e.gc = 3'd0;
        if (k >= 2) begin
            p  = k - 2;
            ht = hv + hf + hsw + hb;
            vt = vv + vf + vsw + vb;
            h  = p % ht;
            v  = (p / ht) % vt;
            e.act = (h < hv) && (v < vv);
            e.hs  = !((h >= hv + hf) && (h < hv + hf + hsw));
            e.vs  = !((v >= vv + vf) && (v < vv + vf + vsw));
            e.ch  = e.act ? model_mem[(v / 16) * 80 + h / 8] : 8'h00;
            e.gr  = 4'(v % 16);
            e.gc  = 3'(h % 8);
        end
        return e;
    endfunction

    task automatic chk_all(input int k);
        exp_t eb, es;
        g_k = k;
        eb = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
        es = model(k, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        chk("big.hsync",  32'(w_hs_b),  32'(eb.hs));
        chk("big.vsync",  32'(w_vs_b),  32'(eb.vs));
        chk("big.active", 32'(w_act_b), 32'(eb.act));
        chk("big.char",   32'(w_ch_b),  32'(eb.ch));
        chk("big.grow",   32'(w_gr_b),  32'(eb.gr));
        chk("big.gcol",   32'(w_gc_b),  32'(eb.gc));
        chk("sml.hsync",  32'(w_hs_s),  32'(es.hs));
        chk("sml.vsync",  32'(w_vs_s),  32'(es.vs));
        chk("sml.active", 32'(w_act_s), 32'(es.act));
        chk("sml.char",   32'(w_ch_s),  32'(es.ch));
        chk("sml.grow",   32'(w_gr_s),  32'(es.gr));
        chk("sml.gcol",   32'(w_gc_s),  32'(es.gc));
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        console_addr  = a;
        console_data  = d;
        console_write = 1'b1;
        if (a < 12'd2400) model_mem[a] = d;
        tick();
        console_write = 1'b0;
    endtask

    task automatic chk_mem(input string tag);
        int bad_b, bad_s;
        bad_b = 0;
        bad_s = 0;
        for (int i = 0; i < 2400; i++) begin
            if (u_dut.r_mem[i] !== model_mem[i]) bad_b++;
            if (u_small.r_mem[i] !== model_mem[i]) bad_s++;
        end
        chk({tag, ".big"}, 32'(bad_b), 32'd0);
        chk({tag, ".sml"}, 32'(bad_s), 32'd0);
    endtask

    initial begin
        int n, k, sel;
        logic [11:0] a;
        reset         = 1'b1;
        pixel_en      = 1'b0;
        console_addr  = 12'd0;
        console_write = 1'b0;
        console_data  = 8'd0;
        for (int i = 0; i < 2400; i++) model_mem[i] = 8'h20;
        tick();
        tick();
        chk_all(0);
        chk("reset.busy", 32'({w_busy_b, w_busy_s}), 32'b11);

        // Partial clear, then reset again at pointer 1000.
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        chk("clr_ptr", 32'(u_dut.r_clr_ptr), 32'd1000);
        chk("busy_mid", 32'(w_busy_b), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid.ptr", 32'(u_dut.r_clr_ptr), 32'd0);
        chk_all(0);
        tick();
        tick();
        reset = 1'b0;

        // Full clear with a console write to cell 5 pending the whole time.
        console_addr  = 12'd5;
        console_data  = 8'h77;
        console_write = 1'b1;
        n = 0;
        while (w_busy_b && n < 3000) begin
            tick();
            n++;
        end
        console_write = 1'b0;
        chk("busy_cycles", 32'(n), 32'd2400);
        chk("busy_pair", 32'({w_busy_b, w_busy_s}), 32'b00);
        chk("cell5", 32'(u_dut.r_mem[5]), 32'h20);
        chk_mem("mem_clear");

        // Back-to-back random writes, biased toward cells visible on the small instance.
        console_write = 1'b1;
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = 12'(($urandom_range(0, 1) * 80) + $urandom_range(0, 7));
                1:       a = 12'($urandom_range(0, 2399));
                2:       a = 12'($urandom_range(2400, 4095));
                default: a = 12'(($urandom_range(0, 20) * 80) + $urandom_range(0, 21));
            endcase
            console_addr = a;
            console_data = 8'($urandom);
            if (a < 12'd2400) model_mem[a] = console_data;
            tick();
        end
        console_write = 1'b0;
        wr(12'd0, 8'h41);
        wr(12'd2399, 8'h5A);
        wr(12'd2400, 8'h55);
        wr(12'd4095, 8'h55);
        chk("cell0", 32'(u_dut.r_mem[0]), 32'h41);
        chk("cell2399", 32'(u_dut.r_mem[2399]), 32'h5A);
        chk_mem("mem_writes");

        // Free-running raster.
        k = 0;
        chk_all(k);
        pixel_en = 1'b1;
        for (int i = 0; i < 17000; i++) begin
            tick();
            k++;
            chk_all(k);
        end

        // Alternating, then random, pixel enable.
        for (int i = 0; i < 6000; i++) begin
            pixel_en = (i < 2000) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            tick();
            if (pixel_en) k++;
            chk_all(k);
        end
        pixel_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
